// File: rtl/fifo_accum_drain.sv
// Drains a burst of len words from an upstream FIFO and sums them (mod 2^DBITS).
// The result is held on sum/sum_valid until the downstream side accepts it.
module fifo_accum_drain #(
    parameter int unsigned DBITS = 64,
    parameter int unsigned LBITS = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [LBITS-1:0] len,
    input  logic             fifo_empty,
    input  logic [DBITS-1:0] fifo_dout,
    output logic             fifo_rd,
    output logic [DBITS-1:0] sum,
    output logic             sum_valid,
    input  logic             sum_ready,
    output logic             busy,
    output logic [LBITS-1:0] words_read
);

    typedef enum logic [1:0] {StIdle, StRead, StDone} state_e;

    state_e           state_q, state_d;
    logic [LBITS-1:0] len_q, len_d;
    logic [LBITS-1:0] issued_q, issued_d;
    logic [LBITS-1:0] words_q, words_d;
    logic [DBITS-1:0] sum_q, sum_d;
    logic             pending_q, pending_d;
    logic             valid_q, valid_d;

    // Gated by reset directly so the strobe drops without waiting for a clock.
    assign fifo_rd = !reset && (state_q == StRead) && !fifo_empty && (issued_q < len_q);

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        issued_d  = issued_q;
        words_d   = words_q;
        sum_d     = sum_q;
        pending_d = pending_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    len_d     = len;
                    sum_d     = '0;
                    words_d   = '0;
                    issued_d  = '0;
                    pending_d = 1'b0;
                    state_d   = (len == '0) ? StDone : StRead;
                end
            end
            StRead: begin
                pending_d = fifo_rd;
                if (fifo_rd) begin
                    issued_d = issued_q + LBITS'(1);
                end
                // Data for a read issued last cycle is on fifo_dout now.
                if (pending_q) begin
                    sum_d   = sum_q + fifo_dout;
                    words_d = words_q + LBITS'(1);
                    if (words_d == len_q) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                if (sum_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        valid_d = (state_d == StDone);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            len_q     <= '0;
            issued_q  <= '0;
            words_q   <= '0;
            sum_q     <= '0;
            pending_q <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            issued_q  <= issued_d;
            words_q   <= words_d;
            sum_q     <= sum_d;
            pending_q <= pending_d;
            valid_q   <= valid_d;
        end
    end

    assign sum        = sum_q;
    assign sum_valid  = valid_q;
    assign busy       = (state_q != StIdle);
    assign words_read = words_q;

endmodule

// File: tb/tb_fifo_accum_drain.sv
// Bench for fifo_accum_drain: a queue-backed FIFO model, a table of directed bursts,
// hand-written corner sequences and randomized bursts checked against summed queue contents.
module tb_fifo_accum_drain;

    logic        clock;
    logic        reset;
    logic        start;
    logic [7:0]  len;
    logic        fifo_empty;
    logic [63:0] fifo_dout;
    logic        fifo_rd;
    logic [63:0] sum;
    logic        sum_valid;
    logic        sum_ready;
    logic        busy;
    logic [7:0]  words_read;

    fifo_accum_drain #(.DBITS(64), .LBITS(8)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .len        (len),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_rd    (fifo_rd),
        .sum        (sum),
        .sum_valid  (sum_valid),
        .sum_ready  (sum_ready),
        .busy       (busy),
        .words_read (words_read)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [63:0] fq[$];
    bit          hold_empty;
    bit          stall_mode;
    int          reads;
    int          rd_while_empty;
    int          total;
    int          bad;

    typedef struct {
        int          n;
        logic [63:0] w[4];
        logic [63:0] exp_sum;
    } vec_t;

    vec_t vt[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic upd_empty();
        fifo_empty = (fq.size() == 0) || hold_empty;
    endtask

    // One clock: sample the strobe before the edge, then service the FIFO after it.
    task automatic cycle();
        logic rd;
        #1;
        rd = fifo_rd;
        if (rd && fifo_empty) rd_while_empty++;
        @(posedge clock);
        #1;
        if (rd) begin
            reads++;
            if (fq.size() > 0) fifo_dout = fq.pop_front();
            else fifo_dout = '0;
        end
        if (stall_mode) hold_empty = ($urandom_range(0, 3) == 0);
        upd_empty();
    endtask

    task automatic run_burst(input int n, output int lat);
        reads = 0;
        start = 1'b1;
        len   = 8'(n);
        cycle();
        start = 1'b0;
        lat   = 0;
        while (!sum_valid && lat < 2000) begin
            cycle();
            lat++;
        end
    endtask

    initial begin
        int          lat;
        int          ec;
        bit          refilled;
        logic [63:0] acc;
        int          n;
        int          extra;

        total = 0; bad = 0; reads = 0; rd_while_empty = 0;
        hold_empty = 0; stall_mode = 0;
        start = 0; len = 0; fifo_dout = '0; sum_ready = 1'b1;
        fifo_empty = 1'b1;
        reset = 1'b1;

        // Reset state
        @(posedge clock); #1;
        check("rst_fifo_rd", fifo_rd, 0);
        check("rst_sum", sum, 0);
        check("rst_sum_valid", sum_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_words_read", words_read, 0);
        @(posedge clock); #1;
        reset = 1'b0;

        // Directed table
        vt[0] = '{n: 4, w: '{64'd1, 64'd2, 64'd3, 64'd4}, exp_sum: 64'd10};
        vt[1] = '{n: 2, w: '{64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd0, 64'd0}, exp_sum: 64'd1};
        vt[2] = '{n: 0, w: '{64'd9, 64'd9, 64'd9, 64'd9}, exp_sum: 64'd0};
        vt[3] = '{n: 1, w: '{64'h1234, 64'd0, 64'd0, 64'd0}, exp_sum: 64'h1234};
        vt[4] = '{n: 3, w: '{64'd100, 64'd200, 64'd300, 64'd0}, exp_sum: 64'd600};
        for (int i = 0; i < 5; i++) begin
            fq.delete();
            for (int k = 0; k < vt[i].n; k++) fq.push_back(vt[i].w[k]);
            hold_empty = 0;
            upd_empty();
            run_burst(vt[i].n, lat);
            check($sformatf("vec%0d_valid", i), sum_valid, 1);
            check($sformatf("vec%0d_sum", i), sum, vt[i].exp_sum);
            check($sformatf("vec%0d_words", i), words_read, 64'(vt[i].n));
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vt[i].n == 0 ? 0 : vt[i].n + 1));
            check($sformatf("vec%0d_reads", i), 64'(reads), 64'(vt[i].n));
            check($sformatf("vec%0d_busy", i), busy, 1);
            cycle();
            check($sformatf("vec%0d_idle", i), busy, 0);
            check($sformatf("vec%0d_valid_drop", i), sum_valid, 0);
        end

        // FIFO runs dry after the first word, refilled after three empty cycles
        fq.delete();
        fq.push_back(64'd9);
        upd_empty();
        reads = 0;
        start = 1'b1; len = 8'd3;
        cycle();
        start = 1'b0;
        ec = 0; refilled = 0; lat = 0;
        while (!sum_valid && lat < 100) begin
            if (fq.size() == 0 && !refilled) begin
                ec++;
                if (ec > 3) begin
                    fq.push_back(64'd5);
                    fq.push_back(64'd6);
                    refilled = 1;
                    upd_empty();
                end
            end
            cycle();
            lat++;
        end
        check("stall_valid", sum_valid, 1);
        check("stall_sum", sum, 64'd20);
        check("stall_words", words_read, 3);
        check("stall_reads", 64'(reads), 3);
        cycle();

        // Hold in DONE with sum_ready low; start pulses must be ignored
        fq.delete();
        fq.push_back(64'd10);
        fq.push_back(64'd20);
        fq.push_back(64'd99);
        upd_empty();
        sum_ready = 1'b0;
        run_burst(2, lat);
        for (int i = 0; i < 10; i++) begin
            start = (i % 2 == 0);
            len   = 8'd1;
            cycle();
            check("hold_sum", sum, 64'd30);
            check("hold_valid", sum_valid, 1);
            check("hold_words", words_read, 2);
        end
        start = 1'b0;
        check("hold_no_reads", 64'(reads), 2);
        sum_ready = 1'b1;
        cycle();
        check("hold_release_idle", busy, 0);

        // Start coincident with the handshake is ignored, honoured one cycle later
        fq.delete();
        fq.push_back(64'd5);
        upd_empty();
        sum_ready = 1'b0;
        run_burst(1, lat);
        check("hs_first_sum", sum, 64'd5);
        fq.push_back(64'd7);
        upd_empty();
        sum_ready = 1'b1;
        start = 1'b1; len = 8'd1;
        cycle();
        check("hs_start_ignored", busy, 0);
        check("hs_valid_drop", sum_valid, 0);
        cycle();
        start = 1'b0;
        check("hs_start_taken", busy, 1);
        lat = 0;
        while (!sum_valid && lat < 100) begin
            cycle();
            lat++;
        end
        check("hs_second_sum", sum, 64'd7);
        cycle();

        // Reset mid-burst after two reads
        fq.delete();
        for (int k = 1; k <= 4; k++) fq.push_back(64'(k));
        upd_empty();
        reads = 0;
        start = 1'b1; len = 8'd4;
        cycle();
        start = 1'b0;
        cycle();
        cycle();
        check("mid_reads", 64'(reads), 2);
        #2;
        reset = 1'b1;
        #1;
        check("mid_fifo_rd", fifo_rd, 0);
        check("mid_sum", sum, 0);
        check("mid_valid", sum_valid, 0);
        check("mid_busy", busy, 0);
        check("mid_words", words_read, 0);
        @(posedge clock); #1;
        reset = 1'b0;
        upd_empty();
        run_burst(2, lat);
        check("post_rst_sum", sum, 64'd7);
        check("post_rst_words", words_read, 2);
        cycle();

        // Randomized bursts against summed queue contents
        for (int it = 0; it < 40; it++) begin
            n = $urandom_range(0, 10);
            extra = $urandom_range(0, 3);
            fq.delete();
            for (int k = 0; k < n + extra; k++) fq.push_back({$urandom, $urandom});
            acc = '0;
            for (int k = 0; k < n; k++) acc += fq[k];
            stall_mode = (it % 2 == 1);
            hold_empty = 0;
            upd_empty();
            run_burst(n, lat);
            check("rnd_valid", sum_valid, 1);
            check("rnd_sum", sum, acc);
            check("rnd_words", words_read, 64'(n));
            check("rnd_reads", 64'(reads), 64'(n));
            if (!stall_mode) check("rnd_latency", 64'(lat), 64'(n == 0 ? 0 : n + 1));
            stall_mode = 0;
            hold_empty = 0;
            cycle();
            check("rnd_idle", busy, 0);
        end

        check("rd_while_empty", 64'(rd_while_empty), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
